// File: rtl/router_pkg.sv
// Shared types and header field helpers for the N-port packet router.
// Field helpers take the header zero-extended to HdrMaxW bits.
package router_pkg;

  localparam int unsigned HdrMaxW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWaitEmpty,
    StLoad,
    StDrop,
    StCheck
  } state_e;

  function automatic logic [HdrMaxW-1:0] hdr_dest(input logic [HdrMaxW-1:0] hdr,
                                                  input int unsigned addr_w);
    logic [HdrMaxW-1:0] mask;
    mask = (HdrMaxW'(1) << addr_w) - HdrMaxW'(1);
    return hdr & mask;
  endfunction

  function automatic logic [HdrMaxW-1:0] hdr_len(input logic [HdrMaxW-1:0] hdr,
                                                 input int unsigned data_w,
                                                 input int unsigned addr_w);
    logic [HdrMaxW-1:0] mask;
    mask = (HdrMaxW'(1) << (data_w - addr_w)) - HdrMaxW'(1);
    return (hdr >> addr_w) & mask;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-port synchronous FIFO with registered read data and an idle-read timeout
// that flushes the whole queue when the reader stalls too long.
module router_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [TW-1:0]     r_tmo;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_rd_data;

  // A pending flush overrides any write or read on the same edge.
  assign w_flush = (r_tmo == TW'(TIMEOUT));
  assign w_push  = i_wr_en && !o_full && !w_flush;
  assign w_pop   = i_rd_en && !o_empty && !w_flush;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_tmo     <= '0;
      r_rd_data <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_tmo    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
      if (o_empty || w_pop) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

endmodule

// File: rtl/pkt_router_n.sv
// One-input, N-output packet router: steers header/payload/parity packets into
// per-destination FIFOs, drops invalid destinations and flags parity/length errors.
module pkt_router_n
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 30
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          pkt_valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          vld_out,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned LEN_W = DATA_W - ADDR_W;

  state_e              r_state;
  state_e              w_state_next;
  logic [DATA_W-1:0]   r_hdr;
  logic [DATA_W-1:0]   r_parity;
  logic [DATA_W-1:0]   r_parity_rx;
  logic [LEN_W-1:0]    r_count;

  logic [ADDR_W-1:0]   w_hdr_dest;
  logic [ADDR_W-1:0]   w_dest;
  logic [LEN_W-1:0]    w_len;
  logic                w_hdr_bad;
  logic                w_hdr_empty;
  logic                w_sel_full;
  logic                w_sel_empty;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_wr_en;
  logic [DATA_W-1:0]   w_rd_data [NUM_PORTS];
  logic                w_wr_req;
  logic [ADDR_W-1:0]   w_wr_port;
  logic [DATA_W-1:0]   w_wr_data;

  assign w_hdr_dest = ADDR_W'(hdr_dest(HdrMaxW'(data_in), ADDR_W));
  assign w_dest     = ADDR_W'(hdr_dest(HdrMaxW'(r_hdr), ADDR_W));
  assign w_len      = LEN_W'(hdr_len(HdrMaxW'(r_hdr), DATA_W, ADDR_W));
  assign w_hdr_bad  = (32'(w_hdr_dest) >= NUM_PORTS);

  always_comb begin
    w_hdr_empty = 1'b0;
    w_sel_full  = 1'b0;
    w_sel_empty = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_hdr_dest == ADDR_W'(p)) begin
        w_hdr_empty = w_empty[p];
      end
      if (w_dest == ADDR_W'(p)) begin
        w_sel_full  = w_full[p];
        w_sel_empty = w_empty[p];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (pkt_valid) begin
          if (w_hdr_bad)        w_state_next = StDrop;
          else if (w_hdr_empty) w_state_next = StLoad;
          else                  w_state_next = StWaitEmpty;
        end
      end
      StWaitEmpty: if (w_sel_empty) w_state_next = StLoad;
      StLoad:      if (!w_sel_full && !pkt_valid) w_state_next = StCheck;
      StDrop:      if (!pkt_valid) w_state_next = StIdle;
      StCheck:     w_state_next = StIdle;
      default:     w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    err       = 1'b0;
    w_wr_req  = 1'b0;
    w_wr_port = w_dest;
    w_wr_data = data_in;
    unique case (r_state)
      StIdle: begin
        if (pkt_valid && !w_hdr_bad && w_hdr_empty) begin
          w_wr_req  = 1'b1;
          w_wr_port = w_hdr_dest;
        end
      end
      StWaitEmpty: begin
        busy = 1'b1;
        if (w_sel_empty) begin
          w_wr_req  = 1'b1;
          w_wr_data = r_hdr;
        end
      end
      StLoad: begin
        busy     = w_sel_full;
        w_wr_req = !w_sel_full;
      end
      StCheck: begin
        busy = 1'b1;
        err  = (r_parity_rx != r_parity) || (r_count != w_len);
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_wr_en[p] = w_wr_req && (w_wr_port == ADDR_W'(p));
    end
  end

  // Parity starts from the header; the count tracks payload words only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hdr       <= '0;
      r_parity    <= '0;
      r_parity_rx <= '0;
      r_count     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (pkt_valid) begin
            r_hdr    <= data_in;
            r_parity <= data_in;
            r_count  <= '0;
          end
        end
        StLoad: begin
          if (!w_sel_full) begin
            if (pkt_valid) begin
              r_parity <= r_parity ^ data_in;
              if (r_count != '1) r_count <= r_count + LEN_W'(1);
            end else begin
              r_parity_rx <= data_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    router_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT)
    ) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .i_wr_en   (w_wr_en[p]),
      .i_wr_data (w_wr_data),
      .i_rd_en   (read_enb[p]),
      .o_rd_data (w_rd_data[p]),
      .o_full    (w_full[p]),
      .o_empty   (w_empty[p])
    );
    assign data_out[p*DATA_W +: DATA_W] = w_rd_data[p];
    assign vld_out[p]                   = ~w_empty[p];
  end

endmodule

// File: tb/tb_pkt_router_n.sv
// Self-checking bench for pkt_router_n: table of packets, directed corner cases and
// a randomized run against a per-port expected-word queue model.
module tb_pkt_router_n;

  logic        clock = 1'b0;
  logic        resetn;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic [2:0]  read_enb;
  logic [23:0] data_out;
  logic [2:0]  vld_out;
  logic        busy;
  logic        err;

  pkt_router_n #(
    .DATA_W     (8),
    .ADDR_W     (2),
    .NUM_PORTS  (3),
    .FIFO_DEPTH (16),
    .TIMEOUT    (30)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .vld_out   (vld_out),
    .busy      (busy),
    .err       (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] hdr;
    int         npay;
    bit         bad_par;
    int         exp_errs;
    bit         is_drop;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] tx_q[$];          // {pkt_valid, word} still to be offered
  logic [7:0] exp_q[3][$];      // words each port's reader must see, in order
  int         rd_mode = 0;      // 0 none, 1 always, 2 random
  int         err_seen = 0;
  int         acc_count = 0;
  bit         last_busy, busy_seen, vld_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    return tx_q.size() + exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
  endfunction

  // Model: a packet to a valid port appears verbatim in that port's queue.
  task automatic queue_pkt(input logic [7:0] hdr, input int npay, input bit bad_par,
                           output int merr);
    logic [7:0] par, w;
    logic [7:0] words[$];
    int         dest, len;
    dest = int'(hdr[1:0]);
    len  = int'(hdr[7:2]);
    par  = hdr;
    words.push_back(hdr);
    for (int i = 0; i < npay; i++) begin
      w = 8'($urandom);
      par ^= w;
      words.push_back(w);
    end
    if (bad_par) par = par ^ 8'hFF;
    foreach (words[i]) tx_q.push_back({1'b1, words[i]});
    tx_q.push_back({1'b0, par});
    if (dest < 3) begin
      foreach (words[i]) exp_q[dest].push_back(words[i]);
      exp_q[dest].push_back(par);
    end
    merr = (dest < 3 && (bad_par || npay != len)) ? 1 : 0;
  endtask

  task automatic step();
    logic [2:0] pops;
    logic [7:0] ew;
    bit         acc;
    @(negedge clock);
    if (tx_q.size() > 0) begin
      pkt_valid = tx_q[0][8];
      data_in   = tx_q[0][7:0];
    end else begin
      pkt_valid = 1'b0;
      data_in   = 8'($urandom);
    end
    for (int p = 0; p < 3; p++) begin
      case (rd_mode)
        0:       read_enb[p] = 1'b0;
        1:       read_enb[p] = 1'b1;
        default: read_enb[p] = ($urandom_range(0, 3) != 0);
      endcase
    end
    #1;
    acc       = (tx_q.size() > 0) && !busy;
    last_busy = busy;
    busy_seen |= busy;
    vld_seen  |= |vld_out;
    if (err) err_seen++;
    pops = read_enb & vld_out;
    @(posedge clock);
    #1;
    if (acc) begin
      void'(tx_q.pop_front());
      acc_count++;
    end
    for (int p = 0; p < 3; p++) begin
      if (pops[p]) begin
        if (exp_q[p].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_port%0d: got %0h expected no word", p, data_out[p*8 +: 8]);
        end else begin
          ew = exp_q[p].pop_front();
          chk($sformatf("data_port%0d", p), 32'(data_out[p*8 +: 8]), 32'(ew));
        end
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    chk({name, "_drained"}, 32'(pending()), 32'd0);
    chk({name, "_vld_idle"}, 32'(vld_out), 32'd0);
  endtask

  vec_t vecs[9];
  int   m, err0, n, exp_errs;

  initial begin
    vecs[0] = '{8'h3A, 14, 1'b0, 0, 1'b0};
    vecs[1] = '{8'h3A, 14, 1'b1, 1, 1'b0};
    vecs[2] = '{8'h0B, 2,  1'b0, 0, 1'b1};
    vecs[3] = '{8'h0D, 2,  1'b0, 1, 1'b0};
    vecs[4] = '{8'h00, 0,  1'b0, 0, 1'b0};
    vecs[5] = '{8'h05, 1,  1'b1, 1, 1'b0};
    vecs[6] = '{8'h07, 1,  1'b0, 0, 1'b1};
    vecs[7] = '{8'h09, 3,  1'b0, 1, 1'b0};
    vecs[8] = '{8'h0F, 0,  1'b1, 0, 1'b1};

    resetn    = 1'b0;
    pkt_valid = 1'b0;
    data_in   = '0;
    read_enb  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_vld_out", 32'(vld_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // 16-word packet to port 2, read starts 10 cycles later.
    err0 = err_seen;
    rd_mode = 0;
    queue_pkt(8'h3A, 14, 1'b0, m);
    repeat (10) step();
    chk("first_vld2", 32'(vld_out[2]), 32'd1);
    rd_mode = 1;
    drain("first", 200);
    chk("first_err", 32'(err_seen - err0), 32'd0);

    for (int i = 0; i < 9; i++) begin
      err0 = err_seen;
      busy_seen = 1'b0;
      vld_seen  = 1'b0;
      rd_mode   = 1;
      queue_pkt(vecs[i].hdr, vecs[i].npay, vecs[i].bad_par, m);
      drain($sformatf("vec%0d", i), 500);
      chk($sformatf("vec%0d_err", i), 32'(err_seen - err0), 32'(vecs[i].exp_errs));
      if (vecs[i].is_drop) begin
        chk($sformatf("vec%0d_busy", i), 32'(busy_seen), 32'd0);
        chk($sformatf("vec%0d_vld", i), 32'(vld_seen), 32'd0);
      end
    end

    // Backpressure: busy rises once the 16-deep FIFO holds 16 words.
    err0 = err_seen;
    rd_mode = 0;
    acc_count = 0;
    last_busy = 1'b0;
    queue_pkt(8'h50, 20, 1'b0, m);
    n = 0;
    while (!last_busy && n < 40) begin
      step();
      n++;
    end
    chk("bp_words_before_busy", 32'(acc_count), 32'd16);
    rd_mode = 1;
    drain("bp", 300);
    chk("bp_err", 32'(err_seen - err0), 32'd0);

    // Unread packet is flushed; the next header goes straight in.
    err0 = err_seen;
    rd_mode = 0;
    queue_pkt(8'h01, 0, 1'b0, m);
    n = 0;
    while (tx_q.size() > 0 && n < 10) begin
      step();
      n++;
    end
    repeat (24) step();
    chk("tmo_hold", 32'(vld_out[1]), 32'd1);
    n = 0;
    while (vld_out[1] && n < 20) begin
      step();
      n++;
    end
    chk("tmo_flushed", 32'(vld_out[1]), 32'd0);
    exp_q[1].delete();
    queue_pkt(8'h05, 1, 1'b0, m);
    step();
    chk("tmo_nowait_hdr", 32'(vld_out[1]), 32'd1);
    rd_mode = 1;
    drain("tmo", 200);
    chk("tmo_err", 32'(err_seen - err0), 32'd0);

    // Randomized packets with random reads.
    err0 = err_seen;
    exp_errs = 0;
    for (int i = 0; i < 40; i++) begin
      logic [5:0] len6;
      logic [1:0] dst2;
      int         len, npay, r;
      len  = $urandom_range(0, 20);
      len6 = 6'(len);
      dst2 = 2'($urandom_range(0, 3));
      r    = $urandom_range(0, 7);
      npay = len;
      if (r == 0) npay = len + 1;
      else if (r == 1 && len > 0) npay = len - 1;
      queue_pkt({len6, dst2}, npay, ($urandom_range(0, 5) == 0), m);
      exp_errs += m;
    end
    rd_mode = 2;
    drain("rand", 20000);
    chk("rand_err_count", 32'(err_seen - err0), 32'(exp_errs));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
